multi_data_sync: RTL and testbench

MULTI_DATA_SYNC -- requirements
Module: multi_data_sync

---
 rtl/multi_data_sync.sv | 86 ++++++++
 tb/tb_multi_data_sync.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/multi_data_sync.sv
// Multi-channel data synchronizer: each channel's asynchronous enable is passed through a
// flop chain, and an edge on the chain output captures that channel's bus into a valid/ready holding register.
module multi_data_sync #(
    parameter int NUM_STAGES   = 2,
    parameter int BUS_WIDTH    = 8,
    parameter int NUM_CHANNELS = 2,
    parameter int TOGGLE_MODE  = 0
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic [NUM_CHANNELS*BUS_WIDTH-1:0] unsync_bus,
    input  logic [NUM_CHANNELS-1:0]           bus_enable,
    input  logic [NUM_CHANNELS-1:0]           sync_ready,
    input  logic [NUM_CHANNELS-1:0]           clr_overrun,
    output logic [NUM_CHANNELS*BUS_WIDTH-1:0] sync_bus,
    output logic [NUM_CHANNELS-1:0]           enable_pulse,
    output logic [NUM_CHANNELS-1:0]           sync_valid,
    output logic [NUM_CHANNELS-1:0]           overrun
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
            logic [NUM_STAGES-1:0] chain_q, chain_d;
            logic                  hist_q, hist_d;
            logic [BUS_WIDTH-1:0]  data_q, data_d;
            logic                  pulse_q, pulse_d;
            logic                  valid_q, valid_d;
            logic                  ovr_q, ovr_d;
            logic                  evt;

            always_comb begin
                chain_d = {chain_q[NUM_STAGES-2:0], bus_enable[gi]};
                hist_d  = chain_q[NUM_STAGES-1];
                if (TOGGLE_MODE != 0) begin
                    evt = chain_q[NUM_STAGES-1] ^ hist_q;
                end else begin
                    evt = chain_q[NUM_STAGES-1] & ~hist_q;
                end

                data_d  = data_q;
                pulse_d = evt;
                valid_d = valid_q;
                ovr_d   = ovr_q;

                // A new capture always wins over a consume in the same cycle
                if (evt) begin
                    data_d  = unsync_bus[gi*BUS_WIDTH +: BUS_WIDTH];
                    valid_d = 1'b1;
                end else if (valid_q && sync_ready[gi]) begin
                    valid_d = 1'b0;
                end

                if (evt && valid_q && !sync_ready[gi]) begin
                    ovr_d = 1'b1;
                end else if (clr_overrun[gi]) begin
                    ovr_d = 1'b0;
                end
            end

            always_ff @(posedge CLK) begin
                if (!RST) begin
                    chain_q <= '0;
                    hist_q  <= 1'b0;
                    data_q  <= '0;
                    pulse_q <= 1'b0;
                    valid_q <= 1'b0;
                    ovr_q   <= 1'b0;
                end else begin
                    chain_q <= chain_d;
                    hist_q  <= hist_d;
                    data_q  <= data_d;
                    pulse_q <= pulse_d;
                    valid_q <= valid_d;
                    ovr_q   <= ovr_d;
                end
            end

            assign sync_bus[gi*BUS_WIDTH +: BUS_WIDTH] = data_q;
            assign enable_pulse[gi] = pulse_q;
            assign sync_valid[gi]   = valid_q;
            assign overrun[gi]      = ovr_q;
        end
    endgenerate

endmodule

// File: tb/tb_multi_data_sync.sv
// Bench for multi_data_sync: directed vector table, a toggle-mode sequence, then random
// stimulus checked against a cycle-level reference model.
module tb_multi_data_sync;
    localparam int NS = 2;
    localparam int BW = 8;
    localparam int NC = 2;

    logic          CLK = 1'b0;
    logic          RST;
    logic [NC*BW-1:0] unsync_bus, sync_bus;
    logic [NC-1:0] bus_enable, sync_ready, clr_overrun;
    logic [NC-1:0] enable_pulse, sync_valid, overrun;

    logic [NC*BW-1:0] t_unsync_bus, t_sync_bus;
    logic [NC-1:0] t_bus_enable, t_sync_ready, t_clr_overrun;
    logic [NC-1:0] t_enable_pulse, t_sync_valid, t_overrun;

    multi_data_sync #(.NUM_STAGES(NS), .BUS_WIDTH(BW), .NUM_CHANNELS(NC), .TOGGLE_MODE(0)) dut (
        .CLK(CLK), .RST(RST), .unsync_bus(unsync_bus), .bus_enable(bus_enable),
        .sync_ready(sync_ready), .clr_overrun(clr_overrun), .sync_bus(sync_bus),
        .enable_pulse(enable_pulse), .sync_valid(sync_valid), .overrun(overrun)
    );

    multi_data_sync #(.NUM_STAGES(NS), .BUS_WIDTH(BW), .NUM_CHANNELS(NC), .TOGGLE_MODE(1)) dut_t (
        .CLK(CLK), .RST(RST), .unsync_bus(t_unsync_bus), .bus_enable(t_bus_enable),
        .sync_ready(t_sync_ready), .clr_overrun(t_clr_overrun), .sync_bus(t_sync_bus),
        .enable_pulse(t_enable_pulse), .sync_valid(t_sync_valid), .overrun(t_overrun)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic [1:0]  en;
        logic [15:0] bus;
        logic [1:0]  rdy;
        logic [1:0]  clr;
        logic [1:0]  e_pulse;
        logic [1:0]  e_valid;
        logic [1:0]  e_ovr;
        logic [15:0] e_bus;
    } vec_t;

    vec_t tbl[$];
    int n_pass = 0;
    int n_total = 0;

    // Reference model: per-edge history of enable samples, event is an edge of the history NS edges back
    logic [NC-1:0]    samp_q[$];
    logic [NC*BW-1:0] m_bus;
    logic [NC-1:0]    m_pulse, m_valid, m_ovr;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endfunction

    function automatic void add(logic rst, logic [1:0] en, logic [15:0] bus, logic [1:0] rdy,
                                logic [1:0] clr, logic [1:0] p, logic [1:0] v, logic [1:0] o,
                                logic [15:0] eb);
        vec_t r;
        r.rst = rst; r.en = en; r.bus = bus; r.rdy = rdy; r.clr = clr;
        r.e_pulse = p; r.e_valid = v; r.e_ovr = o; r.e_bus = eb;
        tbl.push_back(r);
    endfunction

    function automatic void model_step();
        logic [NC-1:0] now, prev;
        logic ev;
        if (!RST) begin
            m_bus = '0; m_pulse = '0; m_valid = '0; m_ovr = '0;
            samp_q.delete();
            for (int i = 0; i < NS + 2; i++) samp_q.push_back('0);
        end else begin
            samp_q.push_back(bus_enable);
            now  = samp_q[samp_q.size() - 1 - NS];
            prev = samp_q[samp_q.size() - 2 - NS];
            for (int c = 0; c < NC; c++) begin
                ev = now[c] && !prev[c];
                m_pulse[c] = ev;
                if (ev && m_valid[c] && !sync_ready[c]) m_ovr[c] = 1'b1;
                else if (clr_overrun[c]) m_ovr[c] = 1'b0;
                if (ev) begin
                    m_bus[c*BW +: BW] = unsync_bus[c*BW +: BW];
                    m_valid[c] = 1'b1;
                end else if (sync_ready[c]) begin
                    m_valid[c] = 1'b0;
                end
            end
            if (samp_q.size() > 32) void'(samp_q.pop_front());
        end
    endfunction

    task automatic tick(input bit chk);
        @(posedge CLK);
        model_step();
        #1;
        if (chk) begin
            check("rand_pulse", 32'(enable_pulse), 32'(m_pulse));
            check("rand_valid", 32'(sync_valid), 32'(m_valid));
            check("rand_overrun", 32'(overrun), 32'(m_ovr));
            check("rand_bus", 32'(sync_bus), 32'(m_bus));
        end
    endtask

    initial begin
        RST = 1'b0; unsync_bus = '0; bus_enable = '0; sync_ready = '0; clr_overrun = '0;
        t_unsync_bus = '0; t_bus_enable = '0; t_sync_ready = '0; t_clr_overrun = '0;

        //  rst en     bus       rdy    clr    pulse  valid  ovr    bus_exp
        add(0, 2'b00, 16'h0000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 16'h0000);
        add(0, 2'b00, 16'h0000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 16'h0000);
        add(1, 2'b01, 16'h0065, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 16'h0000);
        add(1, 2'b01, 16'h0065, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 16'h0000);
        add(1, 2'b01, 16'h0065, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 16'h0065);
        for (int i = 0; i < 5; i++)
            add(1, 2'b01, 16'h00FF, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 16'h0065);
        for (int i = 0; i < 3; i++)
            add(1, 2'b00, 16'h00FF, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 16'h0065);
        add(1, 2'b01, 16'h00F0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 16'h0065);
        add(1, 2'b01, 16'h00F0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 16'h0065);
        add(1, 2'b01, 16'h00F0, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 16'h00F0);
        add(1, 2'b01, 16'h00F0, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 16'h00F0);
        add(1, 2'b00, 16'h00F0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 16'h00F0);
        add(1, 2'b00, 16'h00F0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 16'h00F0);
        add(1, 2'b00, 16'h00F0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 16'h00F0);
        add(1, 2'b11, 16'h3CA5, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 16'h00F0);
        add(1, 2'b11, 16'h3CA5, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 16'h00F0);
        add(1, 2'b11, 16'h3CA5, 2'b11, 2'b00, 2'b11, 2'b11, 2'b00, 16'h3CA5);
        add(1, 2'b11, 16'h3CA5, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 16'h3CA5);
        add(1, 2'b11, 16'h3CA5, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 16'h3CA5);
        for (int i = 0; i < 3; i++)
            add(1, 2'b00, 16'h0000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 16'h3CA5);
        add(1, 2'b01, 16'h0011, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 16'h3CA5);
        add(0, 2'b01, 16'h0011, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 16'h0000);
        add(1, 2'b01, 16'h0022, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 16'h0000);
        add(1, 2'b01, 16'h0022, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 16'h0000);
        add(1, 2'b01, 16'h0022, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 16'h0022);

        foreach (tbl[i]) begin
            RST = tbl[i].rst; bus_enable = tbl[i].en; unsync_bus = tbl[i].bus;
            sync_ready = tbl[i].rdy; clr_overrun = tbl[i].clr;
            tick(0);
            $display("vec %0d: pulse=%b valid=%b ovr=%b bus=%h", i, enable_pulse, sync_valid,
                     overrun, sync_bus);
            check($sformatf("vec%0d_pulse", i), 32'(enable_pulse), 32'(tbl[i].e_pulse));
            check($sformatf("vec%0d_valid", i), 32'(sync_valid), 32'(tbl[i].e_valid));
            check($sformatf("vec%0d_overrun", i), 32'(overrun), 32'(tbl[i].e_ovr));
            check($sformatf("vec%0d_bus", i), 32'(sync_bus), 32'(tbl[i].e_bus));
        end

        // Toggle-mode instance: each edge of ch1 enable yields one pulse on the third edge
        for (int k = 0; k < 2; k++) begin
            t_bus_enable = (k == 0) ? 2'b10 : 2'b00;
            for (int i = 1; i <= 4; i++) begin
                tick(0);
                $display("toggle %0d edge %0d: pulse=%b", k, i, t_enable_pulse);
                check($sformatf("toggle%0d_e%0d_pulse", k, i), 32'(t_enable_pulse),
                      (i == 3) ? 32'h2 : 32'h0);
            end
        end

        for (int n = 0; n < 400; n++) begin
            RST = ($urandom_range(0, 49) != 0);
            for (int c = 0; c < NC; c++) begin
                if ($urandom_range(0, 3) == 0) bus_enable[c] = ~bus_enable[c];
                sync_ready[c]  = $urandom_range(0, 1) == 1;
                clr_overrun[c] = $urandom_range(0, 3) == 0;
            end
            unsync_bus = 16'($urandom);
            tick(1);
            $display("rand %0d: rst=%b en=%b pulse=%b valid=%b ovr=%b bus=%h", n, RST,
                     bus_enable, enable_pulse, sync_valid, overrun, sync_bus);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
